io_port_bank: RTL and testbench

//  Multi-channel successor to the single 8-bit I/O output register at CPU top.

---
 rtl/io_port_bank.sv | 117 +++++++++++
 tb/tb_io_port_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: CHANNELS output registers with INCR/LOAD/CLR control, plus synchronised,
//    change-flagged input ports readable over the CPU I/O bus.
// Latency: ctrl -> io_out 1 cycle; rd -> rdata/rvalid 1 cycle; pin -> change SYNC_STAGES+1.
// Backpressure: none; one ctrl and one rd accepted every cycle, rvalid is a pulse per rd.
// Ports: clk/reset (sync, active-high); sel/ctrl/wdata drive out reg[sel]; rd/rdata/rvalid
//    read synced input[sel] and clear change[sel]; io_in/io_out packed per channel;
//    change is the sticky per-channel flag vector, irq is its OR.
module io_port_bank #(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [SEL_W-1:0]               sel,
   input  logic [1:0]                     ctrl,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic                           rd,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           rvalid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] io_in,
   output logic [CHANNELS*DATA_WIDTH-1:0] io_out,
   output logic [CHANNELS-1:0]            change,
   output logic                           irq
);

   typedef enum logic [1:0] {
      CTRL_NONE = 2'd0,
      CTRL_INCR = 2'd1,
      CTRL_LOAD = 2'd2,
      CTRL_CLR  = 2'd3
   } ctrl_e;

   localparam int WARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

   logic [DATA_WIDTH-1:0] out_q  [CHANNELS];
   logic [DATA_WIDTH-1:0] out_d  [CHANNELS];
   logic [DATA_WIDTH-1:0] sync_q [CHANNELS][SYNC_STAGES];
   logic [DATA_WIDTH-1:0] sync_d [CHANNELS][SYNC_STAGES];
   logic [DATA_WIDTH-1:0] prev_q [CHANNELS];
   logic [DATA_WIDTH-1:0] prev_d [CHANNELS];
   logic [CHANNELS-1:0]   change_q, change_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic [WARM_W-1:0]     warm_q, warm_d;
   logic                  sel_ok;

   assign sel_ok = ({1'b0, sel} < CH_LIM);

   always_comb begin
      logic hit;
      logic det;
      hit      = 1'b0;
      det      = 1'b0;
      // Warm-up masks the synchroniser flushing out its reset zeros against a live pin.
      warm_d   = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
      rvalid_d = rd;
      // Out-of-range reads return zero; in-range reads overwrite this below.
      rdata_d  = rd ? '0 : rdata_q;
      change_d = change_q;
      for (int k = 0; k < CHANNELS; k++) begin
         hit    = sel_ok && (sel == SEL_W'(k));
         out_d[k] = out_q[k];
         if (hit) begin
            case (ctrl)
               CTRL_INCR: out_d[k] = out_q[k] + 1'b1;
               CTRL_LOAD: out_d[k] = wdata;
               CTRL_CLR:  out_d[k] = '0;
               default:   out_d[k] = out_q[k];
            endcase
         end
         sync_d[k][0] = io_in[k*DATA_WIDTH +: DATA_WIDTH];
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[k][s] = sync_q[k][s-1];
         end
         prev_d[k] = sync_q[k][SYNC_STAGES-1];
         det = (sync_q[k][SYNC_STAGES-1] != prev_q[k]) && (warm_q == '0);
         // Read clears the flag, but a change detected on the same edge wins.
         change_d[k] = (change_q[k] && !(rd && hit)) || det;
         if (rd && hit) begin
            rdata_d = sync_q[k][SYNC_STAGES-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q    <= '{default: '0};
         sync_q   <= '{default: '{default: '0}};
         prev_q   <= '{default: '0};
         change_q <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         warm_q   <= WARM_W'(SYNC_STAGES + 1);
      end else begin
         out_q    <= out_d;
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         change_q <= change_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         warm_q   <= warm_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_out
      assign io_out[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign change = change_q;
   assign irq    = |change_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed stimulus against io_port_bank (3 channels, 8 bits, 2 sync stages).
// A transaction-level model tracks what every output must be and is compared each cycle;
// literal expectations at key points pin the model.
module tb_io_port_bank;
   localparam int DW = 8;
   localparam int CH = 3;
   localparam int S  = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      sel;
   logic [1:0]      ctrl;
   logic [DW-1:0]   wdata;
   logic            rd;
   logic [DW-1:0]   rdata;
   logic            rvalid;
   logic [CH*DW-1:0] io_in;
   logic [CH*DW-1:0] io_out;
   logic [CH-1:0]   change;
   logic            irq;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   io_port_bank #(.DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .sel(sel), .ctrl(ctrl), .wdata(wdata), .rd(rd),
      .rdata(rdata), .rvalid(rvalid), .io_in(io_in), .io_out(io_out),
      .change(change), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0]    m_out [CH];
   logic [DW-1:0]    m_rdata;
   logic             m_rvalid;
   logic [CH-1:0]    m_change;
   logic [CH*DW-1:0] pipe [$];   // last S pin samples, oldest first
   logic [CH*DW-1:0] m_syn, m_prev;
   int               since;      // edges since reset released

   always @(posedge clk) begin : model
      logic [CH*DW-1:0] syn_old;
      logic [CH*DW-1:0] prev_old;
      logic [CH-1:0]    det;
      if (reset) begin
         for (int k = 0; k < CH; k++) m_out[k] = '0;
         m_rdata  = '0;
         m_rvalid = 1'b0;
         m_change = '0;
         pipe     = {};
         for (int i = 0; i < S; i++) pipe.push_back('0);
         m_syn    = '0;
         m_prev   = '0;
         since    = 0;
      end else begin
         syn_old  = m_syn;
         prev_old = m_prev;
         det      = '0;
         for (int k = 0; k < CH; k++)
            if (since >= S + 1 && syn_old[k*DW +: DW] != prev_old[k*DW +: DW]) det[k] = 1'b1;
         m_rvalid = rd;
         if (rd) begin
            if (int'(sel) < CH) begin
               m_rdata = syn_old[int'(sel)*DW +: DW];
               m_change[sel] = 1'b0;
            end else begin
               m_rdata = '0;
            end
         end
         m_change = m_change | det;
         if (int'(sel) < CH) begin
            case (ctrl)
               2'd1: m_out[sel] = m_out[sel] + 8'd1;
               2'd2: m_out[sel] = wdata;
               2'd3: m_out[sel] = '0;
               default: ;
            endcase
         end
         pipe.push_back(io_in);
         void'(pipe.pop_front());
         m_syn  = pipe[0];
         m_prev = syn_old;
         if (since < 1000) since++;
      end
   end

   always @(negedge clk) begin : compare
      logic [CH*DW-1:0] exp_out;
      if (chk_en) begin
         for (int k = 0; k < CH; k++) exp_out[k*DW +: DW] = m_out[k];
         check("io_out", 64'(io_out), 64'(exp_out));
         check("rvalid", 64'(rvalid), 64'(m_rvalid));
         check("rdata",  64'(rdata),  64'(m_rdata));
         check("change", 64'(change), 64'(m_change));
         check("irq",    64'(irq),    64'(|m_change));
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1; sel = '0; ctrl = '0; wdata = '0; rd = 1'b0;
      io_in = {CH{8'hA5}};

      // T1: reset with nonzero pins, then no spurious flag during warm-up
      step();
      chk_en = 1'b1;
      step();
      check("t1_io_out", 64'(io_out), 64'h0);
      check("t1_rvalid", 64'(rvalid), 64'h0);
      check("t1_change", 64'(change), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t1_change_hold", 64'(change), 64'h0);
         check("t1_irq_hold",    64'(irq),    64'h0);
      end

      // Pins to zero raises flags on all channels; clear with back-to-back reads
      io_in = '0;
      repeat (4) step();
      check("pre_change_all", 64'(change), 64'h7);
      rd = 1'b1;
      for (int k = 0; k < CH; k++) begin
         sel = 2'(k);
         step();
         check("pre_rd_data", 64'(rdata), 64'h0);
      end
      rd = 1'b0;
      step();
      check("pre_cleared", 64'(change), 64'h0);

      // T2: LOAD/INCR wrap/CLR on ch2
      sel = 2'd2; ctrl = 2'd2; wdata = 8'hFE;
      step();
      check("t2_load", 64'(io_out[23:16]), 64'hFE);
      ctrl = 2'd1;
      step(); check("t2_incr_ff", 64'(io_out[23:16]), 64'hFF);
      step(); check("t2_incr_00", 64'(io_out[23:16]), 64'h00);
      step(); check("t2_incr_01", 64'(io_out[23:16]), 64'h01);
      ctrl = 2'd3;
      step(); check("t2_clr", 64'(io_out[23:16]), 64'h00);
      check("t2_others", 64'(io_out[15:0]), 64'h0);
      ctrl = 2'd0;

      // T3: ch1 pin change driven just after edge 0; flag after edge 3
      io_in = 24'h003C00;
      check("t3_edge0", 64'(change[1]), 64'h0);
      step(); check("t3_edge1", 64'(change[1]), 64'h0);
      step(); check("t3_edge2", 64'(change[1]), 64'h0);
      step(); check("t3_edge3", 64'(change[1]), 64'h1);
      check("t3_irq", 64'(irq), 64'h1);

      // T4: read clears flag; then a read coinciding with a new change keeps it set
      sel = 2'd1; rd = 1'b1;
      step();
      check("t4_rdata", 64'(rdata), 64'h3C);
      check("t4_rvalid", 64'(rvalid), 64'h1);
      check("t4_clear", 64'(change[1]), 64'h0);
      check("t4_irq", 64'(irq), 64'h0);
      rd = 1'b0;
      io_in = 24'h003D00;
      step(); check("t4_rvalid_drop", 64'(rvalid), 64'h0);
      check("t4_rdata_hold", 64'(rdata), 64'h3C);
      step(); check("t4_pre_set", 64'(change[1]), 64'h0);
      rd = 1'b1;
      step();
      check("t4_set_wins", 64'(change[1]), 64'h1);
      check("t4_rdata2", 64'(rdata), 64'h3D);
      rd = 1'b0;

      // T5: out-of-range select
      sel = 2'd3; ctrl = 2'd2; wdata = 8'h55; rd = 1'b1;
      step();
      check("t5_io_out", 64'(io_out), 64'h0);
      check("t5_rdata", 64'(rdata), 64'h0);
      check("t5_rvalid", 64'(rvalid), 64'h1);
      check("t5_flag_kept", 64'(change), 64'h2);
      ctrl = 2'd0; rd = 1'b0;
      step();
      check("t5_rvalid_drop", 64'(rvalid), 64'h0);

      // T6: reset mid-operation clears everything and re-runs warm-up
      sel = 2'd0; ctrl = 2'd2; wdata = 8'h12; io_in = 24'h003D01;
      step();
      check("t6_load", 64'(io_out[7:0]), 64'h12);
      ctrl = 2'd0;
      step(); step();
      check("t6_change0", 64'(change), 64'h3);
      reset = 1'b1;
      step();
      check("t6_io_out", 64'(io_out), 64'h0);
      check("t6_change", 64'(change), 64'h0);
      check("t6_rdata", 64'(rdata), 64'h0);
      check("t6_irq", 64'(irq), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t6_warmup", 64'(change), 64'h0);
      end
      io_in = 24'h773D01;
      step(); step(); step();
      check("t6_post_warmup", 64'(change), 64'h4);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
